// File: rtl/adc_sample_fifo.sv
// Capture FIFO for codec ADC words: one write per sample_tick rising edge,
// read-enable handshake on the system side, plus overflow/drop status.
module adc_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] adc_data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  drop_count,
    input  logic              clr_status
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic              tick_q;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   rptr_q, rptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              overflow_q, overflow_d;
    logic [CNT_W-1:0]  drop_count_q, drop_count_d;

    logic wr_req, rd_accept, wr_accept, drop;
    logic [CNT_W-1:0] drop_base;

    assign empty = (level_q == '0);
    assign full  = (level_q == DEPTH);

    // A write into a full FIFO still lands when a read frees a slot in the same cycle.
    assign wr_req    = sample_tick & ~tick_q;
    assign rd_accept = rd_en & ~empty;
    assign wr_accept = wr_req & (~full | rd_accept);
    assign drop      = wr_req & full & ~rd_accept;

    always_comb begin
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (wr_accept) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (rd_accept) begin
            rptr_d     = rptr_q + 1'b1;
            rd_data_d  = mem_q[rptr_q[ADDR_W-1:0]];
            rd_valid_d = 1'b1;
        end
        level_d = wptr_d - rptr_d;
    end

    // Clear is applied first so a drop in the same cycle still registers.
    always_comb begin
        drop_base    = clr_status ? '0 : drop_count_q;
        overflow_d   = clr_status ? 1'b0 : overflow_q;
        drop_count_d = drop_base;
        if (drop) begin
            overflow_d = 1'b1;
            if (drop_base != '1) begin
                drop_count_d = drop_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick_q       <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            tick_q       <= sample_tick;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            level_q      <= level_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wptr_q[ADDR_W-1:0]] <= adc_data_in;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_adc_sample_fifo.sv
// Scoreboard bench for adc_sample_fifo: expected words are queued when
// written; a negedge monitor pops and compares on every rd_valid pulse.
module tb_adc_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_tick;
    logic [31:0] adc_data_in;
    logic        rd_en;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic [4:0]  level;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        clr_status;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [31:0] sb[$];

    adc_sample_fifo dut (
        .clk        (clk),
        .reset      (reset),
        .sample_tick(sample_tick),
        .adc_data_in(adc_data_in),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .empty      (empty),
        .full       (full),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count),
        .clr_status (clr_status)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        chk_cnt++;
        if (actual === expected) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one stimulus pulse held for 'width' clock edges; returns 1 time unit
    // after the last edge that sampled it.
    task automatic applyStimulus(input logic tick, input logic [31:0] data, input logic rd,
                                 input logic clr, input int width);
        @(posedge clk);
        #1;
        sample_tick = tick;
        adc_data_in = data;
        rd_en       = rd;
        clr_status  = clr;
        repeat (width) @(posedge clk);
        #1;
        sample_tick = 1'b0;
        rd_en       = 1'b0;
        clr_status  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (reset && rd_valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                checkOutput("rd_data", rd_data, sb.pop_front());
            end
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_rd_data"}, rd_data, 32'h0);
        checkOutput({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
        checkOutput({tag, "_empty"}, 32'(empty), 32'd1);
        checkOutput({tag, "_full"}, 32'(full), 32'd0);
        checkOutput({tag, "_level"}, 32'(level), 32'd0);
        checkOutput({tag, "_overflow"}, 32'(overflow), 32'd0);
        checkOutput({tag, "_drop_count"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        reset       = 1'b0;
        sample_tick = 1'b0;
        adc_data_in = '0;
        rd_en       = 1'b0;
        clr_status  = 1'b0;
        #12;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Wide ticks write once each, read back in order.
        applyStimulus(1'b1, 32'hAACCAACC, 1'b0, 1'b0, 3); sb.push_back(32'hAACCAACC);
        applyStimulus(1'b1, 32'h12345678, 1'b0, 1'b0, 3); sb.push_back(32'h12345678);
        applyStimulus(1'b1, 32'h0000FFFF, 1'b0, 1'b0, 3); sb.push_back(32'h0000FFFF);
        checkOutput("t1_level", 32'(level), 32'd3);
        checkOutput("t1_empty", 32'(empty), 32'd0);
        repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        checkOutput("t1_level_after", 32'(level), 32'd0);
        checkOutput("t1_empty_after", 32'(empty), 32'd1);

        // 17 ticks: the 17th is dropped.
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b1, 32'(i), 1'b0, 1'b0, 1);
            if (i <= 16) sb.push_back(32'(i));
        end
        checkOutput("t2_full", 32'(full), 32'd1);
        checkOutput("t2_level", 32'(level), 32'd16);
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        checkOutput("t2_drop_count", 32'(drop_count), 32'd1);
        repeat (16) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        checkOutput("t2_empty", 32'(empty), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1);
        checkOutput("t2_clr_overflow", 32'(overflow), 32'd0);

        // Full FIFO with simultaneous tick and read.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0, 1);
            sb.push_back(32'h100 + 32'(i));
        end
        sb.push_back(32'h1FF);
        applyStimulus(1'b1, 32'h1FF, 1'b1, 1'b0, 1);
        checkOutput("t3_level", 32'(level), 32'd16);
        checkOutput("t3_overflow", 32'(overflow), 32'd0);
        repeat (16) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        checkOutput("t3_empty", 32'(empty), 32'd1);

        // Reads while empty are ignored; tick+read while empty only writes.
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        checkOutput("t4_rd_valid", 32'(rd_valid), 32'd0);
        checkOutput("t4_rd_data_hold", rd_data, 32'h1FF);
        applyStimulus(1'b1, 32'h4444, 1'b1, 1'b0, 1);
        sb.push_back(32'h4444);
        checkOutput("t4_rd_valid_both", 32'(rd_valid), 32'd0);
        checkOutput("t4_level", 32'(level), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);

        // Drop counter saturation and status clear.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'h5000 + 32'(i), 1'b0, 1'b0, 1);
            sb.push_back(32'h5000 + 32'(i));
        end
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 32'hDEAD, 1'b0, 1'b0, 1);
        checkOutput("t5_drop_sat", 32'(drop_count), 32'd255);
        checkOutput("t5_overflow", 32'(overflow), 32'd1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 1);
        checkOutput("t5_clr_overflow", 32'(overflow), 32'd0);
        checkOutput("t5_clr_drop", 32'(drop_count), 32'd0);
        applyStimulus(1'b1, 32'hBEEF, 1'b0, 1'b1, 1);
        checkOutput("t5_clr_drop_overflow", 32'(overflow), 32'd1);
        checkOutput("t5_clr_drop_count", 32'(drop_count), 32'd1);
        repeat (16) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        checkOutput("t5_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-cycle with data stored.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 32'h7000 + 32'(i), 1'b0, 1'b0, 1);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checkResetValues("async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Pointer wrap with interleaved write/read.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 32'hC000 + 32'(i), 1'b0, 1'b0, 1);
            sb.push_back(32'hC000 + 32'(i));
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1);
        end
        checkOutput("t6_level", 32'(level), 32'd0);
        repeat (2) @(posedge clk);
        checkOutput("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
